// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared constants for the programmable sequence counter:
//                power-on code table, its last index, direction encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    // Last index of the power-on sequence (ten codes, 0..9).
    localparam int unsigned DEFAULT_LEN = 9;

    // Power-on contents of the low table entries; everything above is zero.
    localparam int unsigned DEFAULT_SEQ [DEFAULT_LEN+1] = '{7, 4, 9, 0, 2, 1, 3, 8, 6, 11};

    // Traversal direction as driven on the dir input.
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Power-on code for table entry i.
    function automatic int unsigned default_code(input int unsigned i);
        if (i <= DEFAULT_LEN) begin
            return DEFAULT_SEQ[i];
        end
        return 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_table.sv
`default_nettype none
// ============================================================================
//  Module      : seq_table
//  Description : DEPTH x WIDTH code table. Resets to the default sequence,
//                one synchronous write port, two asynchronous read ports
//                (current index and next-step index).
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_table
    import seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_cur,
    output logic [WIDTH-1:0] rd_data_cur,
    input  logic [AW-1:0]    rd_addr_nxt,
    output logic [WIDTH-1:0] rd_data_nxt
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Reset restores the default sequence; otherwise one write per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= WIDTH'(default_code(i));
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Reads see the registered array, so a write is visible the cycle after it.
    assign rd_data_cur = r_mem[rd_addr_cur];
    assign rd_data_nxt = r_mem[rd_addr_nxt];

endmodule
`default_nettype wire

// File: rtl/param_seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : param_seq_counter
//  Description : Programmable arbitrary-sequence counter. Walks a writable
//                code table forward or backward over entries 0..len, with
//                hold, index load, range recovery, terminal count and the
//                T-flip-flop excitation vector for the next step.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_seq_counter
    import seq_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [AW-1:0]    len,
    input  logic             ld,
    input  logic [AW-1:0]    ld_idx,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] q,
    output logic [AW-1:0]    idx,
    output logic [WIDTH-1:0] t_out,
    output logic             tc,
    output logic             range_err
);

    localparam logic [AW-1:0] c_one  = AW'(1);
    localparam logic [AW-1:0] c_zero = '0;

    logic [AW-1:0]    r_idx;
    logic             r_range_err;
    logic [AW-1:0]    w_step;
    logic [AW-1:0]    w_idx_nxt;
    logic             w_range_err;
    logic [WIDTH-1:0] w_code_cur;
    logic [WIDTH-1:0] w_code_step;

    // Index one step away in the current direction, wrapping only at len.
    always_comb begin
        w_step = r_idx;
        if (dir == DIR_REV) begin
            w_step = (r_idx == c_zero) ? len : r_idx - c_one;
        end else begin
            w_step = (r_idx == len) ? c_zero : r_idx + c_one;
        end
    end

    // Next index: load beats range recovery, which beats stepping.
    always_comb begin
        w_idx_nxt   = r_idx;
        w_range_err = 1'b0;
        if (ld) begin
            if (ld_idx <= len) begin
                w_idx_nxt = ld_idx;
            end else begin
                w_idx_nxt   = c_zero;
                w_range_err = 1'b1;
            end
        end else if (r_idx > len) begin
            w_idx_nxt   = c_zero;
            w_range_err = 1'b1;
        end else if (en) begin
            w_idx_nxt = w_step;
        end
    end

    // Index and range-error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= c_zero;
            r_range_err <= 1'b0;
        end else begin
            r_idx       <= w_idx_nxt;
            r_range_err <= w_range_err;
        end
    end

    seq_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr_cur (r_idx),
        .rd_data_cur (w_code_cur),
        .rd_addr_nxt (w_step),
        .rd_data_nxt (w_code_step)
    );

    // q is the table entry at the registered index; a write to that entry
    // (or a move onto the just-written entry) shows up on the next cycle.
    assign q         = w_code_cur;
    assign idx       = r_idx;
    assign range_err = r_range_err;
    assign t_out     = w_code_cur ^ w_code_step;
    assign tc        = en & ~ld & (((dir == DIR_FWD) & (r_idx == len)) |
                                   ((dir == DIR_REV) & (r_idx == c_zero)));

endmodule
`default_nettype wire

// File: tb/tb_param_seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_seq_counter
//  Description : Directed table-driven bench for param_seq_counter with
//                hand-computed expectations, plus a hand-written sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_seq_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       dir;
    logic [3:0] len;
    logic       ld;
    logic [3:0] ld_idx;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] q;
    logic [3:0] idx;
    logic [3:0] t_out;
    logic       tc;
    logic       range_err;

    int n_checks;
    int n_fail;

    param_seq_counter #(
        .WIDTH (4),
        .DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dir       (dir),
        .len       (len),
        .ld        (ld),
        .ld_idx    (ld_idx),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .q         (q),
        .idx       (idx),
        .t_out     (t_out),
        .tc        (tc),
        .range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       dir;
        logic [3:0] len;
        logic       ld;
        logic [3:0] ld_idx;
        logic       wr_en;
        logic [3:0] wr_addr;
        logic [3:0] wr_data;
        logic       chk_pre;
        logic       e_tc;
        logic [3:0] e_t;
        logic [3:0] e_q;
        logic [3:0] e_idx;
        logic       e_re;
    } vec_t;

    vec_t vecs [64];
    int   nv;

    function automatic vec_t mk(input logic r, input logic e, input logic d, input logic [3:0] l,
                                input logic lo, input logic [3:0] li, input logic we,
                                input logic [3:0] wa, input logic [3:0] wd, input logic cp,
                                input logic etc, input logic [3:0] et, input logic [3:0] eq,
                                input logic [3:0] ei, input logic ere);
        vec_t v;
        v.rst = r;  v.en = e;  v.dir = d;  v.len = l;  v.ld = lo;  v.ld_idx = li;
        v.wr_en = we;  v.wr_addr = wa;  v.wr_data = wd;  v.chk_pre = cp;
        v.e_tc = etc;  v.e_t = et;  v.e_q = eq;  v.e_idx = ei;  v.e_re = ere;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;  en = v.en;  dir = v.dir;  len = v.len;  ld = v.ld;
        ld_idx = v.ld_idx;  wr_en = v.wr_en;  wr_addr = v.wr_addr;  wr_data = v.wr_data;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nv       = 0;
        rst = 1'b0; en = 1'b0; dir = 1'b0; len = 4'd9; ld = 1'b0;
        ld_idx = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // reset
        vecs[nv++] = mk(1,0,0,9, 0,0, 0,0,0,  0,0,0,   7,0,0);
        // full forward pass, len=9
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,3,   4,1,0);
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,13,  9,2,0);
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,9,   0,3,0);
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,2,   2,4,0);
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,3,   1,5,0);
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,2,   3,6,0);
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,11,  8,7,0);
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,14,  6,8,0);
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,13, 11,9,0);
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,1,12,  7,0,0);
        // reverse from idx 0
        vecs[nv++] = mk(0,1,1,9, 0,0, 0,0,0,  1,1,12, 11,9,0);
        vecs[nv++] = mk(0,1,1,9, 0,0, 0,0,0,  1,0,13,  6,8,0);
        vecs[nv++] = mk(0,1,1,9, 0,0, 0,0,0,  1,0,14,  8,7,0);
        vecs[nv++] = mk(0,1,1,9, 0,0, 0,0,0,  1,0,11,  3,6,0);
        // forward to idx 8, then shrink len below idx
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,11,  8,7,0);
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,14,  6,8,0);
        vecs[nv++] = mk(0,0,0,5, 0,0, 0,0,0,  1,0,13,  7,0,1);
        vecs[nv++] = mk(0,0,0,5, 0,0, 0,0,0,  1,0,3,   7,0,0);
        // loads: in range, out of range, load beats en, load masks tc
        vecs[nv++] = mk(0,0,0,9, 1,4, 0,0,0,  1,0,3,   2,4,0);
        vecs[nv++] = mk(0,0,0,9, 1,12,0,0,0,  1,0,3,   7,0,1);
        vecs[nv++] = mk(0,1,0,9, 1,7, 0,0,0,  1,0,3,   8,7,0);
        vecs[nv++] = mk(0,1,0,7, 1,2, 0,0,0,  1,0,15,  9,2,0);
        // write-first onto the next index, then pass over it
        vecs[nv++] = mk(0,1,0,9, 0,0, 1,3,15, 1,0,9,  15,3,0);
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,13,  2,4,0);
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,3,   1,5,0);
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,2,   3,6,0);
        // mid-run reset with a write pending: write ignored, table restored
        vecs[nv++] = mk(1,1,0,9, 0,0, 1,0,5,  1,0,11,  7,0,0);
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,3,   4,1,0);
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,13,  9,2,0);
        vecs[nv++] = mk(0,1,0,9, 0,0, 0,0,0,  1,0,9,   0,3,0);
        // single-entry sequence
        vecs[nv++] = mk(0,0,0,0, 1,0, 0,0,0,  1,0,2,   7,0,0);
        vecs[nv++] = mk(0,1,0,0, 0,0, 0,0,0,  1,1,0,   7,0,0);
        vecs[nv++] = mk(0,1,1,0, 0,0, 0,0,0,  1,1,0,   7,0,0);
        // write to the current entry while holding
        vecs[nv++] = mk(0,0,0,0, 0,0, 1,0,10, 1,0,0,  10,0,0);

        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            if (vecs[i].chk_pre) begin
                check($sformatf("v%0d tc", i), int'(tc), int'(vecs[i].e_tc));
                check($sformatf("v%0d t_out", i), int'(t_out), int'(vecs[i].e_t));
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d q", i), int'(q), int'(vecs[i].e_q));
            check($sformatf("v%0d idx", i), int'(idx), int'(vecs[i].e_idx));
            check($sformatf("v%0d range_err", i), int'(range_err), int'(vecs[i].e_re));
        end

        // Range recovery outranks a reverse step, and the pulse lasts one cycle.
        @(negedge clk);
        rst = 0; en = 0; dir = 0; len = 4'd9; ld = 1; ld_idx = 4'd9; wr_en = 0;
        @(posedge clk); #1;
        check("seq load9 idx", int'(idx), 9);
        check("seq load9 q", int'(q), 11);
        @(negedge clk);
        ld = 0; en = 1; dir = 1; len = 4'd3;
        #1;
        check("seq shrink tc", int'(tc), 0);
        @(posedge clk); #1;
        check("seq shrink idx", int'(idx), 0);
        check("seq shrink range_err", int'(range_err), 1);
        check("seq shrink q", int'(q), 10);
        @(negedge clk);
        en = 0;
        @(posedge clk); #1;
        check("seq pulse end range_err", int'(range_err), 0);
        check("seq pulse end idx", int'(idx), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
